mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 1024x32 unified memory between three requesters: program loader (LD),
//  MEM-stage load/store (DM) and IF-stage instruction fetch (IF). Sits between the pipeline
//  stages and the memory array. Grants at most one access per cycle, returns read data tagged
//  to its owner, prevents fetch starvation and freezes pipeline traffic across a halt.
// PARAMETERS
//  ADDR_W      10  memory word-address width (1024 words)
//  DATA_W      32  data word width
//  STARVE_MAX  4   consecutive denied IF cycles before IF outranks DM (range 1..15)
// PORTS
//  clk         in   1       single clock, all state on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  halt_req    in   1       pipeline halted; freeze DM/IF service
//  ld_req      in   1       loader request
//  ld_we       in   1       loader write enable (1=write, 0=read)
//  ld_addr     in   ADDR_W  loader address
//  ld_wdata    in   DATA_W  loader write data
//  ld_gnt      out  1       loader granted this cycle
//  ld_rvalid   out  1       loader read data valid
//  dm_req      in   1       data request
//  dm_we       in   1       data write enable
//  dm_addr     in   ADDR_W  data address
//  dm_wdata    in   DATA_W  data write data
//  dm_gnt      out  1       data granted this cycle
//  dm_rvalid   out  1       data read data valid
//  if_req      in   1       fetch request (always a read)
//  if_addr     in   ADDR_W  fetch address (PC)
//  if_gnt      out  1       fetch granted this cycle
//  if_rvalid   out  1       fetch read data valid
//  rdata       out  DATA_W  shared read data, qualified by *_rvalid
//  mem_en      out  1       memory access enable
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, valid 1 cycle after mem_en&&!mem_we
//  busy        out  1       FSM not in RUN
// BEHAVIOUR
//  Handshake: requester holds req/we/addr/wdata stable until it samples gnt=1 at a posedge;
//   gnt is combinational from current req/state; granted request drives mem_* that cycle.
//  Priority (RUN): LD > DM > IF; exception: if starve_cnt==STARVE_MAX, IF > DM (LD still wins).
//  starve_cnt: +1 per cycle with if_req&&!if_gnt, saturates at STARVE_MAX; cleared on if_gnt
//   or !if_req.
//  Read latency: exactly 1 cycle; owner tag registered at grant; next cycle the owner's
//   rvalid=1 and rdata=mem_rdata. Writes produce no rvalid. One access in flight max; a new
//   grant is allowed in the rvalid cycle (full throughput, 1 access/cycle).
//  mem_en=0 and mem_we=0 when nothing granted; mem_addr/mem_wdata don't-care then.
//  FSM: RUN   -> DRAIN on halt_req (this cycle grants LD only).
//       DRAIN -> HOLD once no read outstanding (at most 1 cycle); grants LD only.
//       HOLD  : only LD served; DM/IF gnt=0; -> RUN when halt_req=0 (DM/IF eligible next cycle).
//   busy=1 in DRAIN/HOLD. halt_req deasserted while in DRAIN: finish drain, go via HOLD to RUN.
//  Simultaneous: req from all three same cycle -> exactly one gnt; same-address RAW across
//   requesters resolved purely by grant order (memory is write-first not required).
//  Reset (rst_n=0, async): state=RUN, starve_cnt=0, owner tag cleared; all gnt, rvalid,
//   mem_en, mem_we, busy=0; rdata=0. Reset mid-read: pending rvalid is dropped, never emitted.
//  Addresses are ADDR_W bits; no wrap/range logic inside the block.
// TESTING
//  1 Reset: rst_n low mid-read of DM @0x010 -> no dm_rvalid after release; all outputs 0.
//  2 IF alone reads 0x000..0x003 back-to-back -> if_gnt every cycle, if_rvalid 1 cycle later,
//    rdata = preloaded words in order.
//  3 DM+IF both request continuously, STARVE_MAX=4 -> DM wins 4 cycles, IF granted on 5th,
//    starve_cnt back to 0; pattern repeats.
//  4 LD write 0xDEADBEEF @0x3FF while DM/IF request -> ld_gnt only; then DM read 0x3FF ->
//    dm_rvalid, rdata=0xDEADBEEF.
//  5 halt_req during IF read -> if_rvalid still delivered, busy=1, DM/IF gnt=0 while held;
//    LD still served; halt_req=0 -> IF granted next cycle, busy=0.
//  6 DM write then IF read same address next cycle -> IF sees new data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-access-per-cycle arbiter for the shared 1024x32 RAM.
// Ports: LD/DM/IF req/gnt/rvalid, shared rdata, mem_* to RAM, halt_req/busy.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_req,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nx;
  logic [3:0] starve_cnt;
  logic       ld_tag;
  logic       dm_tag;
  logic       if_tag;
  logic       run_ok;
  logic       if_pri;

  // Pipeline ports are only eligible in RUN with no halt pending;
  // the loader is served in every state.
  assign run_ok = (state == RUN) && !halt_req;
  assign if_pri = (starve_cnt == SMAX);

  assign ld_gnt = ld_req;
  assign if_gnt = run_ok && !ld_req && if_req
                  && (if_pri || !dm_req);
  assign dm_gnt = run_ok && !ld_req && dm_req
                  && !(if_pri && if_req);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      ld_gnt: begin
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      dm_gnt: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      if_gnt: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  // DRAIN lasts one cycle: no DM/IF grant happens in it, so
  // any pipeline read still in flight completes during it.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (halt_req) state_nx = DRAIN;
      DRAIN:   state_nx = HOLD;
      HOLD:    if (!halt_req) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Owner of the read issued this cycle; RAM data returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_tag <= 1'b0;
      dm_tag <= 1'b0;
      if_tag <= 1'b0;
    end else begin
      ld_tag <= ld_gnt && !ld_we;
      dm_tag <= dm_gnt && !dm_we;
      if_tag <= if_gnt;
    end
  end

  assign ld_rvalid = ld_tag;
  assign dm_rvalid = dm_tag;
  assign if_rvalid = if_tag;
  assign rdata = (ld_tag || dm_tag || if_tag)
                 ? mem_rdata : '0;
  assign busy = (state != RUN);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table and random checks of the arbiter.
// Contains a RAM model and a cycle-count based reference model.
module tb_mem_port_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt_req = 1'b0;
  logic          ld_req = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ref_mem [1024];
  logic          preload = 1'b1;
  int            n_cmp = 0;
  int            n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%08h, want 0x%08h @%0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic idle();
    ld_req = 1'b0;
    ld_we = 1'b0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    if_req = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [9:0] outs();
    return {ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid,
            if_rvalid, mem_en, mem_we, busy, 1'b0};
  endfunction

  typedef struct packed {
    logic       ld;
    logic       ldw;
    logic       dm;
    logic       dmw;
    logic       fi;
    logic [2:0] gnt;
    logic       we;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int            t;
    int            ready_at;
    int            streak;
    int            p_own;
    logic [31:0]   p_dat;
    logic          elig;
    logic          e_ld;
    logic          e_dm;
    logic          e_if;
    logic [AW-1:0] ga;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    #1 chk("reset outs", 32'(outs()), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    preload = 1'b0;
    @(negedge clk);

    // 1: reset lands while a DM read is in flight
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 10'h010;
    #1 chk1("t1 dm_gnt", dm_gnt, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    dm_req = 1'b0;
    #1 chk("t1 reset outs", 32'(outs()), 32'd0);
    chk("t1 reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      #1 chk1("t1 no dm_rvalid", dm_rvalid, 1'b0);
      @(negedge clk);
    end

    // 2: IF back-to-back reads
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        if_req = 1'b1;
        if_addr = AW'(i);
      end else begin
        if_req = 1'b0;
      end
      #1;
      if (i < 4) chk1("t2 if_gnt", if_gnt, 1'b1);
      if (i > 0) begin
        chk1("t2 if_rvalid", if_rvalid, 1'b1);
        chk("t2 rdata", rdata, pat(i - 1));
      end
      @(negedge clk);
    end

    // 3: starvation rotation, DM x4 then IF
    for (int c = 0; c < 10; c++) begin
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_addr = AW'(c);
      if_req = 1'b1;
      if_addr = 10'h100;
      #1;
      chk1("t3 dm_gnt", dm_gnt, (c % 5) != 4);
      chk1("t3 if_gnt", if_gnt, (c % 5) == 4);
      @(negedge clk);
    end
    idle();

    // 4: loader write beats DM and IF, then DM reads it back
    ld_req = 1'b1;
    ld_we = 1'b1;
    ld_addr = 10'h3FF;
    ld_wdata = 32'hDEAD_BEEF;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 10'h3FF;
    if_req = 1'b1;
    if_addr = 10'h000;
    #1 chk("t4 gnts", 32'({ld_gnt, dm_gnt, if_gnt}), 32'h4);
    chk1("t4 mem_we", mem_we, 1'b1);
    chk("t4 mem_addr", 32'(mem_addr), 32'h3FF);
    chk("t4 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    ld_req = 1'b0;
    ld_we = 1'b0;
    if_req = 1'b0;
    #1 chk1("t4 dm_gnt", dm_gnt, 1'b1);
    @(negedge clk);
    dm_req = 1'b0;
    #1 chk1("t4 dm_rvalid", dm_rvalid, 1'b1);
    chk("t4 rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // 5: halt across an IF read
    if_req = 1'b1;
    if_addr = 10'd5;
    #1 chk1("t5 if_gnt", if_gnt, 1'b1);
    @(negedge clk);
    halt_req = 1'b1;
    if_addr = 10'd6;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 10'd8;
    #1 chk1("t5 if_rvalid", if_rvalid, 1'b1);
    chk("t5 rdata", rdata, pat(5));
    chk1("t5 busy run", busy, 1'b0);
    chk("t5 gnt halt", 32'({dm_gnt, if_gnt}), 32'd0);
    @(negedge clk);
    #1 chk1("t5 busy drain", busy, 1'b1);
    chk("t5 gnt drain", 32'({dm_gnt, if_gnt}), 32'd0);
    @(negedge clk);
    ld_req = 1'b1;
    ld_we = 1'b0;
    ld_addr = 10'd7;
    #1 chk1("t5 busy hold", busy, 1'b1);
    chk("t5 gnt hold ld", 32'({ld_gnt, dm_gnt, if_gnt}), 32'h4);
    @(negedge clk);
    ld_req = 1'b0;
    #1 chk1("t5 ld_rvalid", ld_rvalid, 1'b1);
    chk("t5 ld rdata", rdata, pat(7));
    chk("t5 gnt hold", 32'({dm_gnt, if_gnt}), 32'd0);
    @(negedge clk);
    halt_req = 1'b0;
    #1 chk1("t5 busy release", busy, 1'b1);
    chk("t5 gnt release", 32'({dm_gnt, if_gnt}), 32'd0);
    @(negedge clk);
    #1 chk1("t5 busy after", busy, 1'b0);
    chk("t5 gnt after", 32'({dm_gnt, if_gnt}), 32'h1);
    @(negedge clk);
    if_req = 1'b0;
    #1 chk1("t5 if_rvalid 2", if_rvalid, 1'b1);
    chk("t5 rdata 2", rdata, pat(6));
    chk1("t5 dm_gnt", dm_gnt, 1'b1);
    @(negedge clk);
    dm_req = 1'b0;
    #1 chk1("t5 dm_rvalid", dm_rvalid, 1'b1);
    chk("t5 rdata 3", rdata, pat(8));
    @(negedge clk);

    // 6: DM write then IF read of the same word
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 10'h020;
    dm_wdata = 32'h1234_5678;
    #1 chk1("t6 dm_gnt", dm_gnt, 1'b1);
    @(negedge clk);
    dm_req = 1'b0;
    dm_we = 1'b0;
    if_req = 1'b1;
    if_addr = 10'h020;
    #1 chk1("t6 if_gnt", if_gnt, 1'b1);
    chk1("t6 no dm_rvalid", dm_rvalid, 1'b0);
    @(negedge clk);
    if_req = 1'b0;
    #1 chk1("t6 if_rvalid", if_rvalid, 1'b1);
    chk("t6 rdata", rdata, 32'h1234_5678);
    @(negedge clk);

    // priority table, one idle cycle between vectors
    foreach (tbl[k]) begin
      ld_req = tbl[k].ld;
      ld_we = tbl[k].ldw;
      ld_addr = 10'h040;
      ld_wdata = 32'h0BAD_F00D;
      dm_req = tbl[k].dm;
      dm_we = tbl[k].dmw;
      dm_addr = 10'h041;
      dm_wdata = 32'h0C0F_FEE0;
      if_req = tbl[k].fi;
      if_addr = 10'h042;
      #1;
      chk($sformatf("tbl%0d gnt", k),
          32'({ld_gnt, dm_gnt, if_gnt}), 32'(tbl[k].gnt));
      chk1($sformatf("tbl%0d mem_en", k),
           mem_en, |tbl[k].gnt);
      chk1($sformatf("tbl%0d mem_we", k),
           mem_we, tbl[k].we);
      @(negedge clk);
      idle();
    end

    // random traffic against the reference model
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    t = 0;
    ready_at = 0;
    streak = 0;
    p_own = 0;
    p_dat = '0;
    repeat (3000) begin
      if (!ld_req && $urandom_range(0, 9) == 0) begin
        ld_req = 1'b1;
        ld_we = 1'($urandom_range(0, 1));
        ld_addr = AW'($urandom_range(0, 15));
        ld_wdata = $urandom;
      end
      if (!dm_req && $urandom_range(0, 9) < 5) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = AW'($urandom_range(0, 15));
        dm_wdata = $urandom;
      end
      if (!if_req && $urandom_range(0, 9) < 6) begin
        if_req = 1'b1;
        if_addr = AW'($urandom_range(0, 15));
      end
      if (halt_req) halt_req = ($urandom_range(0, 3) != 0);
      else halt_req = ($urandom_range(0, 19) == 0);
      #1;
      elig = !halt_req && (t >= ready_at);
      e_ld = ld_req;
      e_if = elig && !ld_req && if_req
             && (streak == SMAX || !dm_req);
      e_dm = elig && !ld_req && dm_req && !e_if;
      chk("rnd gnt", 32'({ld_gnt, dm_gnt, if_gnt}),
          32'({e_ld, e_dm, e_if}));
      chk1("rnd busy", busy, t < ready_at);
      chk("rnd rvalid", 32'({ld_rvalid, dm_rvalid, if_rvalid}),
          32'({p_own == 1, p_own == 2, p_own == 3}));
      if (p_own != 0) chk("rnd rdata", rdata, p_dat);
      chk1("rnd mem_en", mem_en, e_ld || e_dm || e_if);
      ga = e_ld ? ld_addr : (e_dm ? dm_addr : if_addr);
      if (e_ld || e_dm || e_if) begin
        chk1("rnd mem_we", mem_we,
             (e_ld && ld_we) || (e_dm && dm_we));
        chk("rnd mem_addr", 32'(mem_addr), 32'(ga));
        if (e_ld && ld_we)
          chk("rnd mem_wdata", mem_wdata, ld_wdata);
        if (e_dm && dm_we)
          chk("rnd mem_wdata", mem_wdata, dm_wdata);
      end else begin
        chk1("rnd idle we", mem_we, 1'b0);
      end
      @(posedge clk);
      p_own = 0;
      if (e_ld) begin
        if (ld_we) ref_mem[ld_addr] = ld_wdata;
        else begin
          p_own = 1;
          p_dat = ref_mem[ld_addr];
        end
      end else if (e_dm) begin
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
        else begin
          p_own = 2;
          p_dat = ref_mem[dm_addr];
        end
      end else if (e_if) begin
        p_own = 3;
        p_dat = ref_mem[if_addr];
      end
      if (if_req && !e_if)
        streak = (streak + 1 > SMAX) ? SMAX : streak + 1;
      else
        streak = 0;
      // A halt seen while running freezes three cycles
      // (drain, hold, release); while already frozen it
      // extends the freeze to two cycles past itself.
      if (halt_req) begin
        if (t >= ready_at) ready_at = t + 3;
        else if (t + 2 > ready_at) ready_at = t + 2;
      end
      t++;
      @(negedge clk);
      if (e_ld) ld_req = 1'b0;
      if (e_dm) dm_req = 1'b0;
      if (e_if) if_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
